pipeline_fetch_stage: RTL and testbench

PIPELINE_FETCH_STAGE -- requirements
Module: pipeline_fetch_stage

---
 rtl/pipeline_fetch_stage.sv | 155 +++++++++++++++
 tb/tb_pipeline_fetch_stage.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_fetch_stage.sv
// rtl/pipeline_fetch_stage.sv - instruction fetch stage with one outstanding imem request and IF/ID register
// Optional perf counters (perf_fetch_cnt, perf_bubble_cnt) are built only with `define FETCH_PERF_CNT_EN.
module pipeline_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_fetch,
  input  logic        stall_decode,
  input  logic        pcsrc_decode,
  input  logic [31:0] pc_branch_decode,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic [31:0] instr_decode,
  output logic [31:0] pc_plus4_decode,
  output logic        valid_decode
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_bubble_cnt
`endif
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DROP} state_t;

  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] hold_q, hold_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_plus4_q, pc_plus4_d;
  logic        valid_q, valid_d;

  logic        redirect;
  logic        accept;
  logic        deliver;
  logic [31:0] deliver_data;
  logic [31:0] pc_plus4;
  logic        load_valid;
  logic        load_bubble;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC & WORD_MASK;
      hold_q     <= 32'd0;
      instr_q    <= 32'd0;
      pc_plus4_q <= 32'd0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      hold_q     <= hold_d;
      instr_q    <= instr_d;
      pc_plus4_q <= pc_plus4_d;
      valid_q    <= valid_d;
    end
  end

  always_comb begin
    redirect     = pcsrc_decode && !stall_decode;
    accept       = imem_req_valid && imem_req_ready;
    pc_plus4     = pc_q + 32'd4;
    deliver      = !redirect && !stall_decode &&
                   (((state_q == S_WAIT) && imem_resp_valid) || (state_q == S_HOLD));
    deliver_data = (state_q == S_HOLD) ? hold_q : imem_resp_data;

    state_d = state_q;
    hold_d  = hold_q;
    case (state_q)
      S_REQ: begin
        // A redirect racing an accepted request leaves a response in flight to discard.
        if (redirect) state_d = accept ? S_DROP : S_REQ;
        else if (accept) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (redirect) begin
          state_d = imem_resp_valid ? S_REQ : S_DROP;
        end else if (imem_resp_valid) begin
          if (stall_decode) begin
            state_d = S_HOLD;
            hold_d  = imem_resp_data;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_HOLD: if (!stall_decode) state_d = S_REQ;
      S_DROP: if (imem_resp_valid) state_d = S_REQ;
      default: state_d = S_REQ;
    endcase

    pc_d = pc_q;
    if (redirect) pc_d = pc_branch_decode & WORD_MASK;
    else if (deliver) pc_d = pc_plus4;

    instr_d     = instr_q;
    pc_plus4_d  = pc_plus4_q;
    valid_d     = valid_q;
    load_valid  = 1'b0;
    load_bubble = 1'b0;
    if (!stall_decode) begin
      if (deliver) begin
        instr_d    = deliver_data;
        pc_plus4_d = pc_plus4;
        valid_d    = 1'b1;
        load_valid = 1'b1;
      end else begin
        instr_d     = 32'd0;
        pc_plus4_d  = 32'd0;
        valid_d     = 1'b0;
        load_bubble = 1'b1;
      end
    end
  end

  // Request is masked during reset so the imem never sees a request before release.
  always_comb begin
    imem_req_valid  = (state_q == S_REQ) && !stall_fetch && !reset;
    imem_req_addr   = pc_q;
    instr_decode    = instr_q;
    pc_plus4_decode = pc_plus4_q;
    valid_decode    = valid_q;
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt_q, perf_fetch_cnt_d;
  logic [31:0] perf_bubble_cnt_q, perf_bubble_cnt_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fetch_cnt_q  <= 32'd0;
      perf_bubble_cnt_q <= 32'd0;
    end else begin
      perf_fetch_cnt_q  <= perf_fetch_cnt_d;
      perf_bubble_cnt_q <= perf_bubble_cnt_d;
    end
  end

  always_comb begin
    perf_fetch_cnt_d  = perf_fetch_cnt_q + {31'd0, load_valid};
    perf_bubble_cnt_d = perf_bubble_cnt_q + {31'd0, load_bubble};
    perf_fetch_cnt    = perf_fetch_cnt_q;
    perf_bubble_cnt   = perf_bubble_cnt_q;
  end
`else
  logic unused_load_flags;
  assign unused_load_flags = load_valid ^ load_bubble;
`endif

endmodule

// File: tb/tb_pipeline_fetch_stage.sv
// tb/tb_pipeline_fetch_stage.sv - directed self-checking bench for pipeline_fetch_stage
module tb_pipeline_fetch_stage;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall_fetch = 1'b0;
  logic        stall_decode = 1'b0;
  logic        pcsrc_decode = 1'b0;
  logic [31:0] pc_branch_decode = 32'd0;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b1;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = 32'd0;
  logic [31:0] instr_decode;
  logic [31:0] pc_plus4_decode;
  logic        valid_decode;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_bubble_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  pipeline_fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk),
    .reset(reset),
    .stall_fetch(stall_fetch),
    .stall_decode(stall_decode),
    .pcsrc_decode(pcsrc_decode),
    .pc_branch_decode(pc_branch_decode),
    .imem_req_valid(imem_req_valid),
    .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data),
    .instr_decode(instr_decode),
    .pc_plus4_decode(pc_plus4_decode),
    .valid_decode(valid_decode)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetch_cnt(perf_fetch_cnt),
    .perf_bubble_cnt(perf_bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #1;
    n_tests++;
    if ({imem_req_valid, valid_decode, instr_decode, pc_plus4_decode} !== 66'd0) begin
      $display("FAIL reset_state: req_valid=%0b valid=%0b instr=%h pc4=%h, want all 0",
               imem_req_valid, valid_decode, instr_decode, pc_plus4_decode);
      n_fail++;
    end
    step;
    step;
    reset = 1'b0;
    #1;
    n_tests++;
    if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h0}) begin
      $display("FAIL reset_first_req: valid=%0b addr=%h, want 1 00000000", imem_req_valid, imem_req_addr);
      n_fail++;
    end
  endtask

  task automatic test_zero_wait;
    logic [31:0] d;
    for (int i = 0; i < 3; i++) begin
      d = 32'h1111_1111 * (i + 1);
      n_tests++;
      if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'(4 * i)}) begin
        $display("FAIL zw_req%0d: valid=%0b addr=%h, want 1 %h", i, imem_req_valid, imem_req_addr, 32'(4 * i));
        n_fail++;
      end
      step;
      n_tests++;
      if ({valid_decode, instr_decode, pc_plus4_decode, imem_req_valid} !== 66'd0) begin
        $display("FAIL zw_bubble%0d: valid=%0b instr=%h pc4=%h req_valid=%0b, want all 0",
                 i, valid_decode, instr_decode, pc_plus4_decode, imem_req_valid);
        n_fail++;
      end
      imem_resp_valid = 1'b1;
      imem_resp_data  = d;
      step;
      imem_resp_valid = 1'b0;
      n_tests++;
      if ({valid_decode, instr_decode, pc_plus4_decode} !== {1'b1, d, 32'(4 * (i + 1))}) begin
        $display("FAIL zw_load%0d: valid=%0b instr=%h pc4=%h, want 1 %h %h",
                 i, valid_decode, instr_decode, pc_plus4_decode, d, 32'(4 * (i + 1)));
        n_fail++;
      end
    end
  endtask

  task automatic test_stall_hold;
    stall_decode = 1'b1;
    step;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hDEAD_BEEF;
    step;
    imem_resp_valid = 1'b0;
    step;
    n_tests++;
    if ({valid_decode, instr_decode, pc_plus4_decode, imem_req_valid} !== {1'b1, 32'h3333_3333, 32'd12, 1'b0}) begin
      $display("FAIL hold_ifid: valid=%0b instr=%h pc4=%h req_valid=%0b, want 1 33333333 0000000c 0",
               valid_decode, instr_decode, pc_plus4_decode, imem_req_valid);
      n_fail++;
    end
    stall_decode = 1'b0;
    step;
    n_tests++;
    if ({valid_decode, instr_decode, pc_plus4_decode} !== {1'b1, 32'hDEAD_BEEF, 32'd16}) begin
      $display("FAIL hold_release: valid=%0b instr=%h pc4=%h, want 1 deadbeef 00000010",
               valid_decode, instr_decode, pc_plus4_decode);
      n_fail++;
    end
    stall_fetch = 1'b1;
    #1;
    n_tests++;
    if (imem_req_valid !== 1'b0) begin
      $display("FAIL stall_fetch: req_valid=%0b, want 0", imem_req_valid);
      n_fail++;
    end
    step;
    stall_fetch = 1'b0;
    #1;
    n_tests++;
    if ({imem_req_valid, imem_req_addr, valid_decode} !== {1'b1, 32'd16, 1'b0}) begin
      $display("FAIL stall_fetch_release: valid=%0b addr=%h vdec=%0b, want 1 00000010 0",
               imem_req_valid, imem_req_addr, valid_decode);
      n_fail++;
    end
  endtask

  task automatic test_redirect;
    step;
    pcsrc_decode     = 1'b1;
    pc_branch_decode = 32'h0040_0103;
    step;
    pcsrc_decode = 1'b0;
    n_tests++;
    if ({imem_req_valid, valid_decode, instr_decode} !== 33'd0) begin
      $display("FAIL redir_wait_drop: req_valid=%0b valid=%0b instr=%h, want 0 0 0",
               imem_req_valid, valid_decode, instr_decode);
      n_fail++;
    end
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hBADB_AD00;
    step;
    imem_resp_valid = 1'b0;
    n_tests++;
    if ({imem_req_valid, imem_req_addr, valid_decode, instr_decode} !== {1'b1, 32'h0040_0100, 1'b0, 32'd0}) begin
      $display("FAIL redir_after_drop: valid=%0b addr=%h vdec=%0b instr=%h, want 1 00400100 0 0",
               imem_req_valid, imem_req_addr, valid_decode, instr_decode);
      n_fail++;
    end
    step;
    imem_resp_valid  = 1'b1;
    imem_resp_data   = 32'h7777_7777;
    pcsrc_decode     = 1'b1;
    pc_branch_decode = 32'hFFFF_FFFC;
    step;
    imem_resp_valid = 1'b0;
    pcsrc_decode    = 1'b0;
    n_tests++;
    if ({valid_decode, instr_decode, pc_plus4_decode, imem_req_valid, imem_req_addr} !==
        {1'b0, 32'd0, 32'd0, 1'b1, 32'hFFFF_FFFC}) begin
      $display("FAIL redir_same_resp: vdec=%0b instr=%h pc4=%h valid=%0b addr=%h, want 0 0 0 1 fffffffc",
               valid_decode, instr_decode, pc_plus4_decode, imem_req_valid, imem_req_addr);
      n_fail++;
    end
  endtask

  task automatic test_wrap;
    step;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hCAFE_F00D;
    step;
    imem_resp_valid = 1'b0;
    n_tests++;
    if ({valid_decode, instr_decode, pc_plus4_decode, imem_req_valid, imem_req_addr} !==
        {1'b1, 32'hCAFE_F00D, 32'd0, 1'b1, 32'd0}) begin
      $display("FAIL wrap: vdec=%0b instr=%h pc4=%h valid=%0b addr=%h, want 1 cafef00d 0 1 0",
               valid_decode, instr_decode, pc_plus4_decode, imem_req_valid, imem_req_addr);
      n_fail++;
    end
  endtask

  task automatic test_reset_mid_wait;
    step;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h1234_5678;
    step;
    imem_resp_valid = 1'b0;
    stall_decode    = 1'b1;
    step;
    #2;
    reset = 1'b1;
    #1;
    n_tests++;
    if ({imem_req_valid, valid_decode, instr_decode, pc_plus4_decode} !== 66'd0) begin
      $display("FAIL reset_async: req_valid=%0b valid=%0b instr=%h pc4=%h, want all 0",
               imem_req_valid, valid_decode, instr_decode, pc_plus4_decode);
      n_fail++;
    end
    stall_decode = 1'b0;
    step;
    reset = 1'b0;
    #1;
    n_tests++;
    if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h0}) begin
      $display("FAIL reset_mid_wait_req: valid=%0b addr=%h, want 1 00000000", imem_req_valid, imem_req_addr);
      n_fail++;
    end
  endtask

  task automatic test_redirect_ignored;
    imem_req_ready   = 1'b0;
    stall_decode     = 1'b1;
    pcsrc_decode     = 1'b1;
    pc_branch_decode = 32'h0000_1000;
    step;
    n_tests++;
    if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h0}) begin
      $display("FAIL redir_ignored: valid=%0b addr=%h, want 1 00000000", imem_req_valid, imem_req_addr);
      n_fail++;
    end
    pcsrc_decode   = 1'b0;
    stall_decode   = 1'b0;
    imem_req_ready = 1'b1;
    step;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h0000_0055;
    stall_decode    = 1'b1;
    step;
    imem_resp_valid  = 1'b0;
    stall_decode     = 1'b0;
    pcsrc_decode     = 1'b1;
    pc_branch_decode = 32'h0000_2000;
    step;
    pcsrc_decode = 1'b0;
    n_tests++;
    if ({valid_decode, instr_decode, imem_req_valid, imem_req_addr} !== {1'b0, 32'd0, 1'b1, 32'h2000}) begin
      $display("FAIL redir_hold: vdec=%0b instr=%h valid=%0b addr=%h, want 0 0 1 00002000",
               valid_decode, instr_decode, imem_req_valid, imem_req_addr);
      n_fail++;
    end
  endtask

`ifdef FETCH_PERF_CNT_EN
  task automatic test_perf;
    int exp_fetch;
    int exp_bubble;
    reset = 1'b1;
    step;
    reset      = 1'b0;
    exp_fetch  = 0;
    exp_bubble = 0;
    for (int i = 0; i < 12; i++) begin
      step;
      exp_bubble++;
      imem_resp_valid  = 1'b1;
      imem_resp_data   = 32'h100 + i;
      pcsrc_decode     = (i == 4) || (i == 8);
      pc_branch_decode = 32'(4 * (i + 1));
      step;
      if ((i == 4) || (i == 8)) exp_bubble++;
      else exp_fetch++;
      imem_resp_valid = 1'b0;
      pcsrc_decode    = 1'b0;
    end
    n_tests++;
    if ({perf_fetch_cnt, perf_bubble_cnt} !== {32'(exp_fetch), 32'(exp_bubble)}) begin
      $display("FAIL perf_cnt: fetch=%0d bubble=%0d, want %0d %0d",
               perf_fetch_cnt, perf_bubble_cnt, exp_fetch, exp_bubble);
      n_fail++;
    end
  endtask
`endif

  initial begin
    test_reset;
    test_zero_wait;
    test_stall_hold;
    test_redirect;
    test_wrap;
    test_reset_mid_wait;
    test_redirect_ignored;
`ifdef FETCH_PERF_CNT_EN
    test_perf;
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
